redux_out_uart: RTL and testbench

- Downstream consumer of the redux core's 8-bit `out` (ALU result) bus.
- Captures result values into a small FIFO and serialises them on a UART TX line (8N1, LSB first), so program results can be observed off-chip.
- Optional change filter: only new values are logged, even though `out` is re-driven every cycle.

---
 rtl/redux_out_uart.sv | 179 +++++++++++++++++
 tb/tb_redux_out_uart.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/redux_out_uart.sv
// redux_out_uart: captures the redux core's 8-bit result bus into a small FIFO
// (optionally only when the value changes) and sends it out as 8N1 UART frames.
module redux_out_uart #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 8,
    parameter int DEDUP        = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               data_in,
    input  logic                     capture_en,
    input  logic                     clear_ovf,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [7:0]               drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;

    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [AW:0]     count_q;
    logic [7:0]      last_q;
    logic            last_vld_q;
    logic            ovf_q;
    logic [7:0]      drop_q;

    logic            pop, push, drop, qualify, full, last_cnt;
    logic [7:0]      head;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign head     = mem_q[rd_ptr_q];
    assign last_cnt = (cnt_q == CW'(CLKS_PER_BIT - 1));
    // A capture qualifies if dedup is off, nothing was seen yet, or the value changed.
    assign qualify  = capture_en && ((DEDUP == 0) || !last_vld_q || (data_in != last_q));
    // A full FIFO still accepts a value when the transmitter pops on the same edge.
    assign push     = qualify && (!full || pop);
    assign drop     = qualify && !push;

    // FIFO storage: written on accepted captures only, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

    // FIFO pointers/occupancy, last-sampled value and drop bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            last_q     <= '0;
            last_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            // Last value tracks every enabled sample, dropped or not.
            if (capture_en) begin
                last_q     <= data_in;
                last_vld_q <= 1'b1;
            end
            // Clear takes priority over a drop on the same edge.
            if (clear_ovf) begin
                ovf_q  <= 1'b0;
                drop_q <= '0;
            end else if (drop) begin
                ovf_q <= 1'b1;
                if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            end
        end
    end

    // TX FSM state register; tx is registered so the line never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // TX FSM next state: tx_d always carries the level of the state being entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (last_cnt) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (last_cnt) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shift_q[idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (last_cnt) begin
                    cnt_d = '0;
                    // Back-to-back frames: go straight to START when more data waits.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_redux_out_uart.sv
// Bench for redux_out_uart: two instances (dedup off / on) driven in lockstep,
// each compared every cycle with a frame-level reference model.
module tb_redux_out_uart;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       capture_en = 1'b0;
    logic       clear_ovf = 1'b0;

    logic       tx_w   [2];
    logic       busy_w [2];
    logic       ovf_w  [2];
    logic [2:0] cnt_w  [2];
    logic [7:0] drop_w [2];

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    redux_out_uart #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .DEDUP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .capture_en(capture_en),
        .clear_ovf(clear_ovf), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt_w[0]),
        .overflow(ovf_w[0]), .drop_count(drop_w[0]));

    redux_out_uart #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .DEDUP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .capture_en(capture_en),
        .clear_ovf(clear_ovf), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt_w[1]),
        .overflow(ovf_w[1]), .drop_count(drop_w[1]));

    // Reference model: a queue of pending bytes plus the cycles left in the
    // frame on the line. Index 0 = dedup off, 1 = dedup on.
    logic [7:0] mq [2][$];
    int         rem    [2];
    logic [7:0] cur    [2];
    logic [7:0] last   [2];
    bit         lv     [2];
    bit         m_ovf  [2];
    int         m_drop [2];
    bit         txlog  [2][$];
    logic [7:0] dec [$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            rem[i] = 0; cur[i] = 8'h00; last[i] = 8'h00; lv[i] = 1'b0;
            m_ovf[i] = 1'b0; m_drop[i] = 0;
        end
    endtask

    task automatic model_step(logic cap, logic [7:0] d, logic clr);
        for (int i = 0; i < 2; i++) begin
            int pre;
            bit pop, qual, drp;
            pre = mq[i].size();
            pop = (pre > 0) && (rem[i] <= 1);
            drp = 1'b0;
            if (pop) begin
                cur[i] = mq[i].pop_front();
                rem[i] = FRAME;
            end else if (rem[i] > 0) begin
                rem[i]--;
            end
            qual = cap && (i == 0 || !lv[i] || d != last[i]);
            if (cap) begin last[i] = d; lv[i] = 1'b1; end
            if (qual) begin
                if (pre < DEPTH || pop) mq[i].push_back(d);
                else drp = 1'b1;
            end
            if (clr) begin
                m_ovf[i] = 1'b0; m_drop[i] = 0;
            end else if (drp) begin
                m_ovf[i] = 1'b1;
                if (m_drop[i] < 255) m_drop[i]++;
            end
        end
    endtask

    function automatic logic exp_tx(int i);
        int pos;
        if (rem[i] == 0) return 1'b1;
        pos = (FRAME - rem[i]) / CPB;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return cur[i][pos - 1];
    endfunction

    task automatic check_all(string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s[%0d].tx", tag, i), 32'(tx_w[i]), 32'(exp_tx(i)));
            chk($sformatf("%s[%0d].busy", tag, i), 32'(busy_w[i]), 32'(rem[i] != 0));
            chk($sformatf("%s[%0d].count", tag, i), 32'(cnt_w[i]), 32'(mq[i].size()));
            chk($sformatf("%s[%0d].ovf", tag, i), 32'(ovf_w[i]), 32'(m_ovf[i]));
            chk($sformatf("%s[%0d].drop", tag, i), 32'(drop_w[i]), 32'(m_drop[i]));
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare at negedge.
    task automatic step(string tag, logic cap, logic [7:0] d, logic clr);
        capture_en = cap; data_in = d; clear_ovf = clr;
        @(posedge clk);
        if (rst_n) model_step(cap, d, clr);
        else model_reset();
        @(negedge clk);
        for (int i = 0; i < 2; i++) txlog[i].push_back(tx_w[i]);
        check_all(tag);
    endtask

    task automatic drain(string tag);
        int k;
        k = 0;
        while ((rem[0] != 0 || rem[1] != 0 || mq[0].size() != 0 || mq[1].size() != 0) && k < 2000) begin
            step(tag, 1'b0, 8'h00, 1'b0);
            k++;
        end
        chk({tag, ".drained"}, 32'(k < 2000), 32'd1);
        step(tag, 1'b0, 8'h00, 1'b0);
    endtask

    // Independent UART receiver over the sampled line, one sample per clock.
    task automatic decode(int i, int from);
        int j;
        dec.delete();
        j = from;
        while (j + FRAME <= txlog[i].size()) begin
            if (txlog[i][j] == 1'b0) begin
                logic [7:0] b;
                for (int k = 0; k < 8; k++) b[k] = txlog[i][j + (k + 1) * CPB + CPB / 2];
                dec.push_back(b);
                j += FRAME;
            end else begin
                j++;
            end
        end
    endtask

    task automatic chk_bytes(string tag, logic [7:0] exp [$]);
        chk({tag, ".nbytes"}, 32'(dec.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size() && k < dec.size(); k++)
            chk($sformatf("%s.byte%0d", tag, k), 32'(dec[k]), 32'(exp[k]));
    endtask

    initial begin
        int mark, zeros, first0, busyc, run, k;
        bit exp_bits [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

        // 1. Reset
        model_reset();
        @(negedge clk);
        for (int n = 0; n < 3; n++) step("rst", 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst[%0d].tx1", i), 32'(tx_w[i]), 32'd1);
            chk($sformatf("rst[%0d].busy0", i), 32'(busy_w[i]), 32'd0);
            chk($sformatf("rst[%0d].cnt0", i), 32'(cnt_w[i]), 32'd0);
            chk($sformatf("rst[%0d].ovf0", i), 32'(ovf_w[i]), 32'd0);
            chk($sformatf("rst[%0d].drop0", i), 32'(drop_w[i]), 32'd0);
        end
        rst_n = 1'b1;
        mark = txlog[0].size();
        for (int n = 0; n < 100; n++) step("idle", 1'b0, 8'h00, 1'b0);
        zeros = 0;
        for (int j = mark; j < txlog[0].size(); j++) if (!txlog[0][j]) zeros++;
        chk("idle.tx_zeros", 32'(zeros), 32'd0);

        // 2. Single byte 0xA5
        mark = txlog[0].size();
        busyc = 0;
        step("single", 1'b1, 8'hA5, 1'b0);
        busyc += busy_w[0];
        for (int n = 0; n < 50; n++) begin
            step("single", 1'b0, 8'h00, 1'b0);
            busyc += busy_w[0];
        end
        chk("single.busy_cycles", 32'(busyc), 32'd40);
        chk("single.count", 32'(cnt_w[0]), 32'd0);
        first0 = -1;
        for (int j = mark; j < txlog[0].size() && first0 < 0; j++) if (!txlog[0][j]) first0 = j;
        chk("single.start_found", 32'(first0 >= 0), 32'd1);
        if (first0 >= 0 && first0 + FRAME <= txlog[0].size()) begin
            for (int b = 0; b < FRAME; b++) begin
                int pos;
                bit e;
                pos = b / CPB;
                e = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : exp_bits[pos - 1];
                chk($sformatf("single.bit%0d", b), 32'(txlog[0][first0 + b]), 32'(e));
            end
        end

        // 3. Dedup (instance 1): held value makes one frame per change
        mark = txlog[1].size();
        for (int n = 0; n < 20; n++) step("dedup", 1'b1, 8'h3C, 1'b0);
        for (int n = 0; n < 20; n++) step("dedup", 1'b1, 8'h3D, 1'b0);
        for (int n = 0; n < 20; n++) step("dedup", 1'b1, 8'h3C, 1'b0);
        drain("dedup");
        decode(1, mark);
        chk_bytes("dedup", '{8'h3C, 8'h3D, 8'h3C});
        step("dedup.clr", 1'b0, 8'h00, 1'b1);

        // 4. Overflow: 8 back-to-back captures into a 4-deep FIFO
        mark = txlog[0].size();
        for (int n = 1; n <= 8; n++) step("ovf", 1'b1, 8'(n), 1'b0);
        chk("ovf.flag", 32'(ovf_w[0]), 32'd1);
        chk("ovf.drops", 32'(drop_w[0]), 32'd3);
        drain("ovf");
        decode(0, mark);
        chk_bytes("ovf", '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5});
        chk("ovf.flag_held", 32'(ovf_w[0]), 32'd1);
        step("ovf.clr", 1'b0, 8'h00, 1'b1);
        chk("ovf.cleared", 32'(ovf_w[0]), 32'd0);
        chk("ovf.drop_cleared", 32'(drop_w[0]), 32'd0);

        // 5. Push on the STOP-pop edge while full
        mark = txlog[0].size();
        for (int n = 0; n < 5; n++) step("full", 1'b1, 8'h40 + 8'(n), 1'b0);
        chk("full.count4", 32'(cnt_w[0]), 32'd4);
        k = 0;
        while (rem[0] != 1 && k < 100) begin
            step("full", 1'b0, 8'h00, 1'b0);
            k++;
        end
        chk("full.reached_stop", 32'(k < 100), 32'd1);
        step("full.pushpop", 1'b1, 8'h55, 1'b0);
        chk("full.count_stays4", 32'(cnt_w[0]), 32'd4);
        chk("full.no_ovf", 32'(ovf_w[0]), 32'd0);
        run = busy_w[0] ? 1 : 0;
        for (int n = 0; n < 400; n++) begin
            step("full", 1'b0, 8'h00, 1'b0);
            if (!busy_w[0]) break;
            run++;
        end
        chk("full.busy_run", 32'(run), 32'd200);
        drain("full");
        decode(0, mark);
        chk_bytes("full", '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h55});

        // 6. Async reset during DATA bit 3 with 2 entries queued
        for (int n = 0; n < 3; n++) step("mrst", 1'b1, 8'h61 + 8'(n), 1'b0);
        k = 0;
        while (!(rem[0] != 0 && (FRAME - rem[0]) / CPB == 4) && k < 100) begin
            step("mrst", 1'b0, 8'h00, 1'b0);
            k++;
        end
        chk("mrst.reached_bit3", 32'(k < 100), 32'd1);
        chk("mrst.queued2", 32'(cnt_w[0]), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("mrst[%0d].tx", i), 32'(tx_w[i]), 32'd1);
            chk($sformatf("mrst[%0d].count", i), 32'(cnt_w[i]), 32'd0);
            chk($sformatf("mrst[%0d].busy", i), 32'(busy_w[i]), 32'd0);
        end
        model_reset();
        @(negedge clk);
        for (int n = 0; n < 3; n++) step("mrst", 1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        mark = txlog[0].size();
        for (int n = 0; n < 100; n++) step("mrst.after", 1'b0, 8'h00, 1'b0);
        zeros = 0;
        for (int j = mark; j < txlog[0].size(); j++) if (!txlog[0][j]) zeros++;
        for (int j = mark; j < txlog[1].size(); j++) if (!txlog[1][j]) zeros++;
        chk("mrst.no_frame", 32'(zeros), 32'd0);

        // 7. Random traffic against the model
        for (int n = 0; n < 1500; n++)
            step("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)),
                 1'($urandom_range(0, 31) == 0));
        drain("rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
